// File: rtl/sdram_slot_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sdram_slot_arbiter_if
// Description : Bundle of the three requester ports (p0 = CPU, p1 = video
//               fetch, p2 = disk DMA) and the SDRAM controller port that the
//               slot arbiter sits between.
//   pN_req/we/addr/din/aux : requester -> arbiter
//   pN_ack/valid/dout      : arbiter -> requester
//   mem_clkref/oe/we/addr/din/aux : arbiter -> controller
//   mem_dout               : controller -> arbiter
//   modport slave  : the arbiter's view
//   modport master : the requesters' and controller's view
// Revision    : 1.0  initial release
// ============================================================================
interface sdram_slot_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [22:0] p0_addr;
    logic [7:0]  p0_din;
    logic        p0_aux;
    logic        p0_ack;
    logic        p0_valid;
    logic [15:0] p0_dout;

    logic        p1_req;
    logic        p1_we;
    logic [22:0] p1_addr;
    logic [7:0]  p1_din;
    logic        p1_aux;
    logic        p1_ack;
    logic        p1_valid;
    logic [15:0] p1_dout;

    logic        p2_req;
    logic        p2_we;
    logic [22:0] p2_addr;
    logic [7:0]  p2_din;
    logic        p2_aux;
    logic        p2_ack;
    logic        p2_valid;
    logic [15:0] p2_dout;

    logic        mem_clkref;
    logic        mem_oe;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_aux;
    logic [15:0] mem_dout;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_din, p0_aux,
        output p0_ack, p0_valid, p0_dout,
        input  p1_req, p1_we, p1_addr, p1_din, p1_aux,
        output p1_ack, p1_valid, p1_dout,
        input  p2_req, p2_we, p2_addr, p2_din, p2_aux,
        output p2_ack, p2_valid, p2_dout,
        output mem_clkref, mem_oe, mem_we, mem_addr, mem_din, mem_aux,
        input  mem_dout
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_din, p0_aux,
        input  p0_ack, p0_valid, p0_dout,
        output p1_req, p1_we, p1_addr, p1_din, p1_aux,
        input  p1_ack, p1_valid, p1_dout,
        output p2_req, p2_we, p2_addr, p2_din, p2_aux,
        input  p2_ack, p2_valid, p2_dout,
        input  mem_clkref, mem_oe, mem_we, mem_addr, mem_din, mem_aux,
        output mem_dout
    );
endinterface
`default_nettype wire

// File: rtl/sdram_slot_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sdram_slot_arbiter
// Description : Time-slot arbiter sharing one 8-bit-write / 16-bit-read SDRAM
//               controller port between three requesters. Each 8-clock slot
//               carries at most one access; p0 has fixed priority, p1/p2
//               alternate round-robin. Slots are left idle during controller
//               init and after REFRESH_MAX consecutive grants so the
//               controller can auto-refresh. Completion (pN_valid, read data)
//               is returned at phase 3 of the slot after the grant.
// Ports       : clk   - system clock, shared with the SDRAM controller
//               reset - synchronous, active-high
//               bus   - sdram_slot_arbiter_if.slave (requesters + controller)
// Revision    : 1.0  initial release
// ============================================================================
module sdram_slot_arbiter #(
    parameter int SLOT_LEN    = 8,
    parameter int INIT_SLOTS  = 32,
    parameter int REFRESH_MAX = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    sdram_slot_arbiter_if.slave        bus
);
    localparam int INIT_W = $clog2(INIT_SLOTS + 1);
    localparam int BUSY_W = $clog2(REFRESH_MAX + 1);

    localparam logic [2:0]        c_PH_LAST    = 3'(SLOT_LEN - 1);
    localparam logic [2:0]        c_PH_DELIVER = 3'd2;  // registered -> visible in phase 3
    localparam logic [INIT_W-1:0] c_INIT_LOAD  = INIT_W'(INIT_SLOTS);
    localparam logic [BUSY_W-1:0] c_BUSY_MAX   = BUSY_W'(REFRESH_MAX);

    // Slot type, updated once per slot at the phase-7 boundary
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [2:0]        phase_q;
    logic [2:0]        phase_d;
    logic [INIT_W-1:0] init_q;
    logic [BUSY_W-1:0] busy_q;
    logic              rr_p2_q;       // 0: p1 wins a p1/p2 tie, 1: p2 wins
    logic [1:0]        slot_port_q;
    logic [2:0]        ack_q;
    logic [2:0]        valid_q;
    logic [15:0]       dout_q [3];
    logic [22:0]       maddr_q;
    logic [7:0]        mdin_q;
    logic              maux_q;
    logic              tag_vld_q;
    logic [1:0]        tag_port_q;
    logic              tag_rd_q;

    logic [2:0]        req;
    logic              arb_now;
    logic              deliver_now;
    logic [INIT_W-1:0] init_dec;
    logic              slot_blocked;
    logic              gnt_vld;
    logic [1:0]        gnt_port;
    logic [22:0]       sel_addr;
    logic [7:0]        sel_din;
    logic              sel_aux;
    logic              sel_we;
    logic              strobe_win;
    logic              rd_strobe;
    logic              wr_strobe;

    assign req          = {bus.p2_req, bus.p1_req, bus.p0_req};
    assign arb_now      = (phase_q == c_PH_LAST);
    assign deliver_now  = (phase_q == c_PH_DELIVER) && tag_vld_q;
    assign phase_d      = arb_now ? 3'd0 : phase_q + 3'd1;
    assign strobe_win   = ~phase_q[2];    // phases 0-3

    // The hold-off test uses the counter value the arbitrated slot will see,
    // so exactly INIT_SLOTS slots after reset are forced idle.
    assign init_dec     = (init_q != '0) ? init_q - 1'b1 : '0;
    assign slot_blocked = (init_dec != '0) || (busy_q == c_BUSY_MAX);

    // ------------------------------------------------------------------
    // Grant selection: p0 fixed priority, then p1/p2 round-robin
    // ------------------------------------------------------------------
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_port = 2'd0;
        if (!slot_blocked) begin
            if (req[0]) begin
                gnt_vld  = 1'b1;
                gnt_port = 2'd0;
            end else if (req[1] && (!req[2] || !rr_p2_q)) begin
                gnt_vld  = 1'b1;
                gnt_port = 2'd1;
            end else if (req[2]) begin
                gnt_vld  = 1'b1;
                gnt_port = 2'd2;
            end
        end
    end

    always_comb begin
        sel_addr = bus.p0_addr;
        sel_din  = bus.p0_din;
        sel_aux  = bus.p0_aux;
        sel_we   = bus.p0_we;
        case (gnt_port)
            2'd1: begin
                sel_addr = bus.p1_addr;
                sel_din  = bus.p1_din;
                sel_aux  = bus.p1_aux;
                sel_we   = bus.p1_we;
            end
            2'd2: begin
                sel_addr = bus.p2_addr;
                sel_din  = bus.p2_din;
                sel_aux  = bus.p2_aux;
                sel_we   = bus.p2_we;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Slot-type FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arb_now) begin
            if (!gnt_vld) begin
                state_d = S_IDLE;
            end else if (sel_we) begin
                state_d = S_WRITE;
            end else begin
                state_d = S_READ;
            end
        end
    end

    // One rising strobe edge per granted slot; an idle slot keeps both low
    // which the controller takes as its refresh opportunity.
    always_comb begin
        rd_strobe = 1'b0;
        wr_strobe = 1'b0;
        case (state_q)
            S_READ:  rd_strobe = strobe_win;
            S_WRITE: wr_strobe = strobe_win;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Slot timing, counters, latched access and completion tag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= 3'd0;
            init_q      <= c_INIT_LOAD;
            busy_q      <= '0;
            rr_p2_q     <= 1'b0;
            slot_port_q <= 2'd0;
            ack_q       <= 3'b000;
            valid_q     <= 3'b000;
            maddr_q     <= 23'd0;
            mdin_q      <= 8'd0;
            maux_q      <= 1'b0;
            tag_vld_q   <= 1'b0;
            tag_port_q  <= 2'd0;
            tag_rd_q    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                dout_q[i] <= 16'd0;
            end
        end else begin
            phase_q <= phase_d;
            ack_q   <= 3'b000;
            valid_q <= 3'b000;

            if (arb_now) begin
                init_q <= init_dec;

                // The slot now ending becomes the pending completion. Its
                // delivery (phase 2 of the next slot) happens before this
                // register is written again, so consecutive grants never
                // overwrite an undelivered tag.
                tag_vld_q  <= (state_q != S_IDLE);
                tag_port_q <= slot_port_q;
                tag_rd_q   <= (state_q == S_READ);

                if (gnt_vld) begin
                    ack_q       <= 3'b001 << gnt_port;
                    slot_port_q <= gnt_port;
                    maddr_q     <= sel_addr;
                    mdin_q      <= sel_din;
                    maux_q      <= sel_aux;
                    busy_q      <= (busy_q == c_BUSY_MAX) ? busy_q : busy_q + 1'b1;
                    if (gnt_port != 2'd0) begin
                        rr_p2_q <= (gnt_port == 2'd1);
                    end
                end else begin
                    busy_q <= '0;
                end
            end

            if (deliver_now) begin
                valid_q   <= 3'b001 << tag_port_q;
                tag_vld_q <= 1'b0;
                for (int i = 0; i < 3; i++) begin
                    if (tag_rd_q && (tag_port_q == 2'(i))) begin
                        dout_q[i] <= bus.mem_dout;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.p0_ack     = ack_q[0];
    assign bus.p1_ack     = ack_q[1];
    assign bus.p2_ack     = ack_q[2];
    assign bus.p0_valid   = valid_q[0];
    assign bus.p1_valid   = valid_q[1];
    assign bus.p2_valid   = valid_q[2];
    assign bus.p0_dout    = dout_q[0];
    assign bus.p1_dout    = dout_q[1];
    assign bus.p2_dout    = dout_q[2];

    assign bus.mem_clkref = strobe_win;
    assign bus.mem_oe     = rd_strobe;
    assign bus.mem_we     = wr_strobe;
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_din    = mdin_q;
    assign bus.mem_aux    = maux_q;
endmodule
`default_nettype wire

// File: tb/tb_sdram_slot_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sdram_slot_arbiter
// Description : Directed bench for sdram_slot_arbiter. Requester tasks push
//               the expected completion into per-port queues; a negedge
//               monitor checks acks, strobes, latency and read data. A small
//               controller model stores writes replicated into both bytes
//               and returns {8'h5A, addr[7:0]} for unwritten locations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sdram_slot_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sdram_slot_arbiter_if bus();

    sdram_slot_arbiter #(
        .SLOT_LEN   (8),
        .INIT_SLOTS (32),
        .REFRESH_MAX(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    logic [2:0]  t_req = 3'b000;
    logic [2:0]  t_we  = 3'b000;
    logic [2:0]  t_aux = 3'b000;
    logic [22:0] t_addr [3];
    logic [7:0]  t_din  [3];
    logic [15:0] mem_rdata = 16'd0;

    assign bus.p0_req  = t_req[0];  assign bus.p1_req  = t_req[1];  assign bus.p2_req  = t_req[2];
    assign bus.p0_we   = t_we[0];   assign bus.p1_we   = t_we[1];   assign bus.p2_we   = t_we[2];
    assign bus.p0_aux  = t_aux[0];  assign bus.p1_aux  = t_aux[1];  assign bus.p2_aux  = t_aux[2];
    assign bus.p0_addr = t_addr[0]; assign bus.p1_addr = t_addr[1]; assign bus.p2_addr = t_addr[2];
    assign bus.p0_din  = t_din[0];  assign bus.p1_din  = t_din[1];  assign bus.p2_din  = t_din[2];
    assign bus.mem_dout = mem_rdata;

    logic [2:0]  d_ack;
    logic [2:0]  d_valid;
    logic [15:0] d_dout [3];
    assign d_ack   = {bus.p2_ack, bus.p1_ack, bus.p0_ack};
    assign d_valid = {bus.p2_valid, bus.p1_valid, bus.p0_valid};
    assign d_dout[0] = bus.p0_dout;
    assign d_dout[1] = bus.p1_dout;
    assign d_dout[2] = bus.p2_dout;

    // cyc counts clocks since the last reset edge; its low bits are the slot phase
    int         cyc = 0;
    logic [2:0] ph;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
    assign ph = cyc[2:0];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    endtask

    typedef struct packed {
        logic        rd;
        logic [15:0] data;
    } exp_t;

    exp_t       exp_q [3][$];
    int         ack_t [3][$];
    int         order_q[$];
    logic [2:0] pend = 3'b000;
    int         last_ack [3];
    int         acks     [3];

    // ---------------- controller model ----------------
    logic [15:0] mem_model [int];
    logic        oe_prev = 1'b0;
    logic        we_prev = 1'b0;
    logic        rd_pend = 1'b0;
    logic [22:0] rd_addr = 23'd0;

    always @(negedge clk) begin
        if (bus.mem_we && !we_prev) mem_model[int'(bus.mem_addr)] = {bus.mem_din, bus.mem_din};
        if (bus.mem_oe && !oe_prev) begin
            rd_pend = 1'b1;
            rd_addr = bus.mem_addr;
        end
        if (rd_pend && ph == 3'd5) begin
            if (mem_model.exists(int'(rd_addr))) mem_rdata = mem_model[int'(rd_addr)];
            else                                 mem_rdata = {8'h5A, rd_addr[7:0]};
            rd_pend = 1'b0;
        end
        oe_prev = bus.mem_oe;
        we_prev = bus.mem_we;
    end

    // ---------------- monitor / scoreboard ----------------
    logic slot_rd = 1'b0;
    logic slot_wr = 1'b0;

    always @(negedge clk) begin : mon
        exp_t e;
        int   t;
        if (!reset) begin
            if (ph == 3'd0) begin
                slot_rd = 1'b0;
                slot_wr = 1'b0;
            end
            for (int p = 0; p < 3; p++) begin
                if (d_ack[p]) begin
                    if (!pend[p]) begin
                        chk($sformatf("p%0d_unexpected_ack", p), 32'(d_ack[p]), 32'd0);
                    end else begin
                        chk($sformatf("p%0d_ack_phase", p), 32'(ph), 32'd0);
                        chk($sformatf("p%0d_mem_addr", p), 32'(bus.mem_addr), 32'(t_addr[p]));
                        chk($sformatf("p%0d_mem_aux", p), 32'(bus.mem_aux), 32'(t_aux[p]));
                        if (t_we[p]) chk($sformatf("p%0d_mem_din", p), 32'(bus.mem_din), 32'(t_din[p]));
                        pend[p]     = 1'b0;
                        last_ack[p] = cyc;
                        acks[p]++;
                        ack_t[p].push_back(cyc);
                        order_q.push_back(p);
                        slot_rd = !t_we[p];
                        slot_wr = t_we[p];
                    end
                end
                if (d_valid[p]) begin
                    if (exp_q[p].size() == 0) begin
                        chk($sformatf("p%0d_unexpected_valid", p), 32'(d_valid[p]), 32'd0);
                    end else begin
                        e = exp_q[p].pop_front();
                        t = (ack_t[p].size() != 0) ? ack_t[p].pop_front() : -100;
                        chk($sformatf("p%0d_latency", p), 32'(cyc - t), 32'd11);
                        if (e.rd) chk($sformatf("p%0d_dout", p), 32'(d_dout[p]), 32'(e.data));
                    end
                end
            end
            chk("mem_oe", 32'(bus.mem_oe), 32'(slot_rd && (ph < 3'd4)));
            chk("mem_we", 32'(bus.mem_we), 32'(slot_wr && (ph < 3'd4)));
            chk("mem_clkref", 32'(bus.mem_clkref), 32'(ph < 3'd4));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a posedge; returns one clock after the ack cycle.
    task automatic access(input int p, input logic we, input logic [22:0] a, input logic [7:0] d,
                          input logic ax, input logic [15:0] exp_data, input int exp_ack);
        exp_t e;
        int   n;
        e.rd   = !we;
        e.data = exp_data;
        exp_q[p].push_back(e);
        t_we[p]   = we;
        t_addr[p] = a;
        t_din[p]  = d;
        t_aux[p]  = ax;
        pend[p]   = 1'b1;
        t_req[p]  = 1'b1;
        n = 0;
        while (pend[p] && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        t_req[p] = 1'b0;
        if (pend[p]) begin
            chk($sformatf("p%0d_ack_timeout", p), 32'(pend[p]), 32'd0);
            pend[p] = 1'b0;
            void'(exp_q[p].pop_back());
        end else if (exp_ack >= 0) begin
            chk($sformatf("p%0d_ack_cycle", p), 32'(last_ack[p]), 32'(exp_ack));
        end
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        chk("rst_ack",    32'(d_ack),          32'd0);
        chk("rst_valid",  32'(d_valid),        32'd0);
        chk("rst_dout0",  32'(d_dout[0]),      32'd0);
        chk("rst_dout1",  32'(d_dout[1]),      32'd0);
        chk("rst_dout2",  32'(d_dout[2]),      32'd0);
        chk("rst_oe",     32'(bus.mem_oe),     32'd0);
        chk("rst_we",     32'(bus.mem_we),     32'd0);
        chk("rst_addr",   32'(bus.mem_addr),   32'd0);
        chk("rst_din",    32'(bus.mem_din),    32'd0);
        chk("rst_aux",    32'(bus.mem_aux),    32'd0);
        chk("rst_clkref", 32'(bus.mem_clkref), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cyc %0d expected completion", cyc);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin : stim
        int exp_order [7] = '{0, 0, 0, 1, 2, 1, 2};
        int a0;
        int base2;
        for (int i = 0; i < 3; i++) begin
            t_addr[i]   = 23'd0;
            t_din[i]    = 8'd0;
            last_ack[i] = -1;
            acks[i]     = 0;
        end

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values();

        // 1: init hold-off, first ack at phase 0 of slot 32
        while (cyc != 5) begin
            @(posedge clk);
            #1;
        end
        access(0, 1'b0, 23'h000040, 8'h00, 1'b0, 16'h5A40, 256);

        // 2: write then read back, replicated byte
        access(0, 1'b1, 23'h000123, 8'hA5, 1'b0, 16'h0000, -1);
        access(0, 1'b0, 23'h000123, 8'h00, 1'b0, 16'hA5A5, -1);
        idle_clks(24);

        // 3: all three requesting, p0 priority then p1/p2 alternate
        order_q.delete();
        fork
            begin
                access(0, 1'b1, 23'h000200, 8'h3C, 1'b0, 16'h0000, -1);
                access(0, 1'b0, 23'h000200, 8'h00, 1'b0, 16'h3C3C, -1);
                access(0, 1'b0, 23'h000201, 8'h00, 1'b1, 16'h5A01, -1);
            end
            begin
                access(1, 1'b0, 23'h010010, 8'h00, 1'b0, 16'h5A10, -1);
                access(1, 1'b0, 23'h010011, 8'h00, 1'b1, 16'h5A11, -1);
            end
            begin
                access(2, 1'b1, 23'h020030, 8'h77, 1'b1, 16'h0000, -1);
                access(2, 1'b0, 23'h020030, 8'h00, 1'b0, 16'h7777, -1);
            end
        join
        chk("order_len", 32'(order_q.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < order_q.size()) chk($sformatf("order_%0d", i), 32'(order_q[i]), 32'(exp_order[i]));
        end
        idle_clks(24);

        // 4: p1 back-to-back, forced refresh slot after 16 grants
        access(1, 1'b0, 23'h030000, 8'h00, 1'b0, 16'h5A00, -1);
        a0 = last_ack[1];
        for (int i = 1; i < 18; i++) begin
            base2 = (i < 16) ? a0 + 8 * i : a0 + 8 * (i + 1);
            access(1, i[0], 23'h030000 + 23'(i), 8'(8'h40 + i), 1'b0, {8'h5A, 8'(i)}, base2);
        end
        idle_clks(24);

        // 6: p2 request inside one slot only, dropped before phase 7
        a0 = acks[2];
        while (ph != 3'd0) begin
            @(posedge clk);
            #1;
        end
        t_we[2]   = 1'b0;
        t_addr[2] = 23'h040000;
        t_req[2]  = 1'b1;
        while (ph != 3'd5) begin
            @(posedge clk);
            #1;
        end
        t_req[2] = 1'b0;
        idle_clks(24);
        chk("p2_short_req_acks", 32'(acks[2]), 32'(a0));

        // 5: reset at phase 2 of a granted read slot
        access(0, 1'b0, 23'h000055, 8'h00, 1'b0, 16'h5A55, -1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q[0].delete();
        ack_t[0].delete();
        @(negedge clk);
        check_reset_values();
        a0 = acks[0];
        idle_clks(300);
        chk("post_reset_no_ack", 32'(acks[0]), 32'(a0));

        for (int p = 0; p < 3; p++) begin
            chk($sformatf("p%0d_pending_left", p), 32'(exp_q[p].size()), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
